// File: rtl/cache_sa_engine.sv
// cache_sa_engine: set-associative tag/state engine with FIFO/LRU replacement and WB/WT policies.
// Define CACHE_MISS_RATE_EN to add a serially divided permille miss-rate output.
module cache_sa_engine #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 64,
  parameter int NUM_SETS    = 16,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              replace_policy,
  input  logic              write_policy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_wb,
  output logic [ADDR_W-1:0] resp_wb_addr,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_read_misses,
  output logic [CNT_W-1:0]  num_write_misses,
`ifdef CACHE_MISS_RATE_EN
  output logic [11:0]       miss_rate,
  output logic              miss_rate_valid,
`endif
  output logic [CNT_W-1:0]  num_writebacks
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wb_addr_q, wb_addr_d;
  logic we_q, we_d, rpol_q, rpol_d, wpol_q, wpol_d;
  logic hit_q, hit_d, wb_q, wb_d, alloc_q, alloc_d;
  logic [AGE_W-1:0] way_q, way_d;
  logic [TAG_W-1:0] tag_q [NUM_SETS][WAYS];
  logic [TAG_W-1:0] tag_d [NUM_SETS][WAYS];
  logic [AGE_W-1:0] age_q [NUM_SETS][WAYS];
  logic [AGE_W-1:0] age_d [NUM_SETS][WAYS];
  logic [WAYS-1:0] valid_q [NUM_SETS];
  logic [WAYS-1:0] valid_d [NUM_SETS];
  logic [WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAYS-1:0] dirty_d [NUM_SETS];
  logic [AGE_W-1:0] ptr_q [NUM_SETS];
  logic [AGE_W-1:0] ptr_d [NUM_SETS];
  logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d, rm_q, rm_d, wm_q, wm_d, wbc_q, wbc_d;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic hit_c, inv_c, alloc_c;
  logic [AGE_W-1:0] hit_way, inv_way, lru_way, victim;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction
  assign idx = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign tag = addr_q[ADDR_W-1:OFF_W+IDX_W];
  assign req_ready = (state_q == IDLE);
  assign resp_valid = (state_q == UPDATE);
  assign resp_hit = hit_q;
  assign resp_wb = wb_q;
  assign resp_wb_addr = wb_addr_q;
  assign num_reads = rd_q;
  assign num_writes = wr_q;
  assign num_read_misses = rm_q;
  assign num_write_misses = wm_q;
  assign num_writebacks = wbc_q;
  always_comb begin
    hit_c = 1'b0;
    hit_way = '0;
    inv_c = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_c = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_c = 1'b1;
        inv_way = AGE_W'(w);
      end
    end
    victim = inv_c ? inv_way : rpol_q ? lru_way : ptr_q[idx];
    alloc_c = !hit_c && !(wpol_q && we_q);
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    rpol_d = rpol_q;
    wpol_d = wpol_q;
    hit_d = hit_q;
    wb_d = wb_q;
    wb_addr_d = wb_addr_q;
    alloc_d = alloc_q;
    way_d = way_q;
    tag_d = tag_q;
    age_d = age_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    ptr_d = ptr_q;
    rd_d = rd_q;
    wr_d = wr_q;
    rm_d = rm_q;
    wm_d = wm_q;
    wbc_d = wbc_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        we_d = req_we;
        rpol_d = replace_policy;
        wpol_d = write_policy;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        hit_d = hit_c;
        alloc_d = alloc_c;
        way_d = hit_c ? hit_way : victim;
        wb_d = alloc_c && valid_q[idx][victim] && dirty_q[idx][victim];
        wb_addr_d = (alloc_c && valid_q[idx][victim] && dirty_q[idx][victim]) ?
                    {tag_q[idx][victim], idx, {OFF_W{1'b0}}} : '0;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (hit_q && we_q && !wpol_q) dirty_d[idx][way_q] = 1'b1;
        if (alloc_q) begin
          valid_d[idx][way_q] = 1'b1;
          tag_d[idx][way_q] = tag;
          dirty_d[idx][way_q] = we_q && !wpol_q;
          if (way_q == ptr_q[idx])
            ptr_d[idx] = (ptr_q[idx] == AGE_W'(WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
        end
        if ((hit_q || alloc_q) && rpol_q) begin
          for (int w = 0; w < WAYS; w++)
            if (age_q[idx][w] < age_q[idx][way_q]) age_d[idx][w] = age_q[idx][w] + 1'b1;
          age_d[idx][way_q] = '0;
        end
        rd_d = sat_inc(rd_q, !we_q);
        wr_d = sat_inc(wr_q, we_q);
        rm_d = sat_inc(rm_q, !we_q && !hit_q);
        wm_d = sat_inc(wm_q, we_q && !hit_q);
        wbc_d = sat_inc(wbc_q, wb_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      rpol_q <= 1'b0;
      wpol_q <= 1'b0;
      hit_q <= 1'b0;
      wb_q <= 1'b0;
      wb_addr_q <= '0;
      alloc_q <= 1'b0;
      way_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= AGE_W'(w);
        end
      end
      rd_q <= '0;
      wr_q <= '0;
      rm_q <= '0;
      wm_q <= '0;
      wbc_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      rpol_q <= rpol_d;
      wpol_q <= wpol_d;
      hit_q <= hit_d;
      wb_q <= wb_d;
      wb_addr_q <= wb_addr_d;
      alloc_q <= alloc_d;
      way_q <= way_d;
      tag_q <= tag_d;
      age_q <= age_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      ptr_q <= ptr_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      rm_q <= rm_d;
      wm_q <= wm_d;
      wbc_q <= wbc_d;
    end
  end
`ifdef CACHE_MISS_RATE_EN
  localparam int DW = CNT_W + 23;
  logic [DW-1:0] rem_q, rem_d, den_q, den_d;
  logic [11:0] quo_q, quo_d, mr_q, mr_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, zero_q, zero_d, mrv_q, mrv_d, ge;
  logic [CNT_W:0] acc_sum, mis_sum;
  assign miss_rate = mr_q;
  assign miss_rate_valid = mrv_q;
  // Quotient never exceeds 1000, so twelve restoring steps against den<<11 suffice.
  always_comb begin
    rem_d = rem_q;
    den_d = den_q;
    quo_d = quo_q;
    mr_d = mr_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    zero_d = zero_q;
    mrv_d = mrv_q;
    acc_sum = {1'b0, rd_d} + {1'b0, wr_d};
    mis_sum = {1'b0, rm_d} + {1'b0, wm_d};
    ge = rem_q >= den_q;
    if (state_q == UPDATE || (busy_q && state_q == IDLE && req_valid)) begin
      rem_d = DW'(mis_sum) * DW'(1000);
      den_d = DW'(acc_sum) << 11;
      zero_d = (acc_sum == '0);
      quo_d = '0;
      cnt_d = '0;
      busy_d = 1'b1;
      mrv_d = 1'b0;
    end else if (busy_q) begin
      rem_d = ge ? rem_q - den_q : rem_q;
      den_d = den_q >> 1;
      quo_d = {quo_q[10:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == 4'd11) begin
        busy_d = 1'b0;
        mrv_d = 1'b1;
        mr_d = zero_q ? '0 : {quo_q[10:0], ge};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      mr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      zero_q <= 1'b0;
      mrv_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      den_q <= den_d;
      quo_q <= quo_d;
      mr_q <= mr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      zero_q <= zero_d;
      mrv_q <= mrv_d;
    end
  end
`endif
endmodule

// File: doc/cache_sa_engine.md
Name: cache_sa_engine

Overview:
- Parametrised set-associative cache tag/state engine; successor to the single-config cache model.
- Accepts one address access at a time and resolves hit/miss against tag, valid and dirty arrays.
- Supports FIFO or LRU replacement and write-back/write-allocate or write-through/no-write-allocate policies.
- Keeps saturating statistics counters; sits between the trace-driven testbench/stimulus source and the statistics reporting logic.

Parameters:
- ADDR_W, 32, access address width in bits
- BLOCK_BYTES, 64, line size in bytes; power of two; OFF_W = log2(BLOCK_BYTES)
- NUM_SETS, 16, number of sets; power of two; IDX_W = log2(NUM_SETS)
- WAYS, 4, associativity; power of two, 1..16; AGE_W = max(1, log2(WAYS))
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  access request
- req_ready  out  1  engine can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- replace_policy  in  1  0 = FIFO, 1 = LRU; sampled at accept
- write_policy  in  1  0 = write-back + write-allocate, 1 = write-through + no-write-allocate; sampled at accept
- resp_valid  out  1  one-cycle pulse, access resolved
- resp_hit  out  1  access hit; valid with resp_valid
- resp_wb  out  1  dirty victim evicted; valid with resp_valid
- resp_wb_addr  out  ADDR_W  line address of evicted victim: {tag, index, OFF_W zeros}
- num_reads, num_writes  out  CNT_W  access counts
- num_read_misses, num_write_misses  out  CNT_W  miss counts
- num_writebacks  out  CNT_W  dirty evictions

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset clears all valid/dirty bits, LRU ages (way w gets age w), FIFO pointers and counters; FSM goes to IDLE; resp_valid/resp_hit/resp_wb = 0, resp_wb_addr = 0.
- Reset mid-operation aborts the access: no resp_valid, no counter update.
- Address split: offset = addr[OFF_W-1:0] (ignored); index = addr[OFF_W+IDX_W-1:OFF_W]; tag = remaining upper bits.
- FSM:
  - IDLE: req_ready = 1. On req_valid, latch addr, we and policies, then go to LOOKUP.
  - LOOKUP: compare the tag against all ways of the set. Hit = valid && tag equal. Select the victim, then go to UPDATE.
  - UPDATE: write arrays, update counters, pulse resp_valid, then go to IDLE.
- Latency: accept at cycle N; resp_valid at N+2; next accept at N+3 at the earliest.
- Victim selection:
  - Lowest-index invalid way if any.
  - Otherwise LRU selects the way with age WAYS-1; FIFO selects the per-set pointer way.
- LRU update (LRU mode, on hit or fill): ways with age below the touched way's age increment; the touched way gets age 0. Ages are not updated in FIFO mode.
- FIFO pointer advances (mod WAYS) only on a fill into the pointer way. It does not advance on hits or on fills into invalid ways other than the pointer way.
- Write-back mode:
  - Write hit sets dirty.
  - Read or write miss fills the victim (valid = 1, new tag); dirty = req_we.
  - If the victim was valid and dirty: resp_wb = 1, resp_wb_addr = victim line address, num_writebacks increments.
- Write-through mode:
  - Dirty is never set.
  - Write miss does not allocate; arrays and ages are unchanged.
  - Read miss allocates.
  - resp_wb is always 0.
- Counters:
  - num_reads/num_writes increment per resolved access.
  - num_read_misses/num_write_misses increment on a miss.
  - All counters saturate at all-ones.
- Policy changes take effect at the next accept; arrays are not flushed.

Optional Feature:
- CACHE_MISS_RATE_EN
- Defined: adds outputs miss_rate (12 bits, permille = total_misses*1000/total_accesses, truncated) and miss_rate_valid.
  - After each UPDATE, a serial restoring divider (one quotient bit per cycle) recomputes the value.
  - miss_rate_valid goes low at start and high when done.
  - A new accept during division restarts the divider.
  - With zero accesses, miss_rate = 0.
  - Reset clears both outputs.
- Undefined: ports and divider absent; the core is unchanged.

Test Plan:
Defaults apply (64 B lines, 16 sets, 4 ways; set-0 stride 0x400).
- Read 0x040 twice → first resp_hit=0, second resp_hit=1; num_reads=2, num_read_misses=1; with the macro, miss_rate=500.
- LRU: read 0x000, 0x400, 0x800, 0xC00 (4 misses), then 0x000 (hit), then 0x1000 (miss) → 0x400 is evicted; re-read 0x400 misses, 0x000 hits.
- FIFO: same sequence → 0x1000 evicts 0x000; re-read 0x000 misses.
- Write-back, FIFO: write 0x000 (miss, dirty), read 0x400, 0x800, 0xC00, read 0x1000 → resp_wb=1, resp_wb_addr=0x000, num_writebacks=1, num_write_misses=1.
- Write-through: write 0x2000 → miss, no allocate; read 0x2000 → miss; resp_wb=0 throughout; num_writebacks=0.
- Reset asserted during LOOKUP of read 0x040 → no resp_valid, all counters 0; a subsequent read of 0x040 misses.
